inst_sched: RTL and testbench

Host instruction queue and issue scheduler placed between the AvMM IO write port and `ctrl_unit`. It buffers 32-bit instruction words that the host writes back-to-back. It releases one word at a time to `ctrl_unit` only when the resource that instruction uses is idle. It also gives the host queue status, an overflow flag and barrier completion.

---
 rtl/inst_sched.sv | 159 +++++++++++++++
 tb/tb_inst_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sched.sv
// Host instruction queue with resource-aware, one-at-a-time issue to ctrl_unit.
// Barriers retire in the scheduler itself and pulse sync_done instead of issuing.
//
// state   | meaning
// S_IDLE  | queue empty, nothing in flight
// S_CHECK | head word waits for its resources to go idle
// S_ISSUE | inst_valid strobe, head popped on exit
// S_WAIT  | guard window until ctrl_unit reports started/finished
module inst_sched #(
    parameter int DEPTH     = 16,
    parameter int GUARD_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             h2f_io,
    input  logic                    h2f_write,
    input  logic                    flush,
    input  logic                    cu_isrunning,
    input  logic                    ldst_busy,
    input  logic                    move_busy,
    input  logic                    eu_busy,
    output logic [31:0]             inst_out,
    output logic                    inst_valid,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    q_full,
    output logic                    q_empty,
    output logic                    q_overflow,
    output logic                    sync_done,
    output logic                    sched_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT} state_t;

    state_t         state, state_nxt;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic [GW-1:0]  guard;
    logic           overflow, sync_q;
    logic [31:0]    head;
    logic [2:0]     op;
    logic           ldst_idle, res_ok, ready, is_barrier;
    logic           full, empty, push, pop, drop;

    assign head       = mem[rd_ptr];
    assign op         = head[31:29];
    assign is_barrier = (op == 3'b111);
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);

    // Mover and load-storer share the RF RAM, so data classes wait on both.
    assign ldst_idle = !ldst_busy && !move_busy;

    always_comb begin
        res_ok = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011: res_ok = ldst_idle;
            3'b100:                         res_ok = !eu_busy;
            default:                        res_ok = ldst_idle && !eu_busy;
        endcase
    end

    assign ready = !cu_isrunning && res_ok && !empty;

    assign pop  = !flush && ((state == S_ISSUE) ||
                             (state == S_CHECK && is_barrier && ready));
    assign push = h2f_write && !flush && (!full || pop);
    assign drop = h2f_write && !flush && full && !pop;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= h2f_io;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            sync_q   <= 1'b0;
            guard    <= '0;
        end else begin
            sync_q <= (state == S_CHECK) && pop;
            if (state == S_ISSUE)
                guard <= GW'(GUARD_CYC - 1);
            else if (state == S_WAIT && guard != '0)
                guard <= guard - GW'(1);
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (!empty)
                    state_nxt = S_CHECK;
            S_CHECK:
                if (ready) begin
                    if (is_barrier)
                        state_nxt = (count_nxt != '0) ? S_CHECK : S_IDLE;
                    else
                        state_nxt = S_ISSUE;
                end
            S_ISSUE:
                state_nxt = S_WAIT;
            S_WAIT:
                if (guard == '0 && !cu_isrunning)
                    state_nxt = empty ? S_IDLE : S_CHECK;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        inst_valid = (state == S_ISSUE);
        inst_out   = inst_valid ? head : 32'h0;
        sched_busy = (state != S_IDLE) || !empty;
    end

    assign q_count    = count;
    assign q_full     = full;
    assign q_empty    = empty;
    assign q_overflow = overflow;
    assign sync_done  = sync_q;

endmodule

// File: tb/tb_inst_sched.sv
// Bench for inst_sched: directed scenarios plus randomized traffic, checked
// against an ordered word scoreboard and the resource/spacing rules.
module tb_inst_sched;
    localparam int DEPTH = 16;
    localparam int GUARD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] h2f_io = '0;
    logic        h2f_write = 1'b0;
    logic        flush = 1'b0;
    logic        cu_isrunning = 1'b0;
    logic        ldst_busy = 1'b0;
    logic        move_busy = 1'b0;
    logic        eu_busy = 1'b0;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [$clog2(DEPTH):0] q_count;
    logic        q_full, q_empty, q_overflow, sync_done, sched_busy;

    inst_sched #(.DEPTH(DEPTH), .GUARD_CYC(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .h2f_io(h2f_io), .h2f_write(h2f_write),
        .flush(flush), .cu_isrunning(cu_isrunning), .ldst_busy(ldst_busy),
        .move_busy(move_busy), .eu_busy(eu_busy), .inst_out(inst_out),
        .inst_valid(inst_valid), .q_count(q_count), .q_full(q_full),
        .q_empty(q_empty), .q_overflow(q_overflow), .sync_done(sync_done),
        .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: words still owed to ctrl_unit (or to retire as barriers), in push order.
    logic [31:0] exp_q[$];
    int n_issue = 0, n_sync = 0, last_iv = -1, last_sync = -1;
    bit p_cu = 0, p_l = 0, p_m = 0, p_e = 0;

    function automatic bit ready_for(input logic [2:0] op, input bit cu, input bit l,
                                     input bit m, input bit e);
        if (cu) return 1'b0;
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: return !l && !m;
            3'd4:                   return !e;
            default:                return !l && !m && !e;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] w;
        if (rst_n) begin
            if (inst_valid) begin
                check_val("iv_while_cu", cu_isrunning, 0);
                if (exp_q.size() == 0)
                    check_val("issue_unexpected", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    check_val("issue_word", inst_out, w);
                end
                check_val("issue_ready", ready_for(inst_out[31:29], p_cu, p_l, p_m, p_e), 1);
                if (last_iv >= 0)
                    check_val("issue_gap", (cyc - last_iv) >= GUARD + 2, 1);
                last_iv = cyc;
                n_issue++;
            end
            if (sync_done) begin
                if (exp_q.size() == 0)
                    check_val("sync_unexpected", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    check_val("sync_is_barrier", w[31:29], 3'b111);
                end
                check_val("sync_ready", ready_for(3'b111, p_cu, p_l, p_m, p_e), 1);
                last_sync = cyc;
                n_sync++;
            end
        end
        p_cu = cu_isrunning; p_l = ldst_busy; p_m = move_busy; p_e = eu_busy;
    end

    // ctrl_unit stand-in: runs for a while after each accepted instruction.
    int cu_len_cfg = 0;
    bit cu_rand = 0;
    int cu_cnt = 0;
    always begin
        @(negedge clk);
        if (inst_valid)
            cu_cnt = cu_rand ? int'($urandom_range(0, 5)) : cu_len_cfg;
        @(posedge clk);
        #1;
        if (cu_cnt > 0) begin
            cu_isrunning = 1'b1;
            cu_cnt--;
        end else
            cu_isrunning = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input bit expect_it);
        h2f_io = w;
        h2f_write = 1'b1;
        tick();
        h2f_write = 1'b0;
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while ((!q_empty || sched_busy || exp_q.size() != 0) && k < max_cyc) begin
            tick();
            k++;
        end
        check_val("drain_in_time", k < max_cyc, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, inst_valid, 0);
        check_val({tag, "_out"}, inst_out, 0);
        check_val({tag, "_count"}, q_count, 0);
        check_val({tag, "_full"}, q_full, 0);
        check_val({tag, "_empty"}, q_empty, 1);
        check_val({tag, "_ovf"}, q_overflow, 0);
        check_val({tag, "_sync"}, sync_done, 0);
        check_val({tag, "_busy"}, sched_busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, base_s, fall_cyc, k;
        bit wr;
        logic [31:0] w;

        // Reset
        repeat (3) tick();
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        // Single issue latency
        push(32'h0000_0123, 1);
        check_val("single_count1", q_count, 1);
        tick();
        check_val("single_t1_valid", inst_valid, 0);
        tick();
        check_val("single_t2_valid", inst_valid, 1);
        check_val("single_t2_out", inst_out, 32'h0000_0123);
        check_val("single_t2_count", q_count, 1);
        tick();
        check_val("single_t3_count", q_count, 0);
        check_val("single_t3_valid", inst_valid, 0);
        wait_idle(50);

        // Resource blocking
        ldst_busy = 1'b1;
        push(32'h4000_0000, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("blocked_no_issue", inst_valid, 0);
        end
        ldst_busy = 1'b0;
        tick();
        check_val("unblock_issue", inst_valid, 1);
        check_val("unblock_out", inst_out, 32'h4000_0000);
        wait_idle(50);

        // Guard and spacing
        cu_len_cfg = 3;
        base = n_issue;
        for (int i = 1; i <= 3; i++) push(32'h8000_0000 + i, 1);
        wait_idle(100);
        check_val("guard_issues", n_issue - base, 3);

        // Overflow
        cu_len_cfg = 2;
        eu_busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) push(32'h8000_0100 + i, i < DEPTH);
        tick();
        check_val("ovf_full", q_full, 1);
        check_val("ovf_flag", q_overflow, 1);
        check_val("ovf_count", q_count, DEPTH);
        check_val("ovf_no_issue", n_issue - base, 3);
        eu_busy = 1'b0;
        base = n_issue;
        wait_idle(400);
        check_val("ovf_issue_count", n_issue - base, DEPTH);
        check_val("ovf_sticky", q_overflow, 1);

        // Barrier
        cu_len_cfg = 0;
        base = n_issue;
        base_s = n_sync;
        push(32'h0000_0A00, 1);
        push(32'hE000_0000, 1);
        push(32'h8000_0B00, 1);
        k = 0;
        while (n_issue == base && k < 20) begin
            tick();
            k++;
        end
        check_val("bar_load_issued", n_issue - base, 1);
        ldst_busy = 1'b1;
        repeat (10) tick();
        check_val("bar_no_sync_yet", n_sync - base_s, 0);
        check_val("bar_no_exec_yet", n_issue - base, 1);
        fall_cyc = cyc;
        ldst_busy = 1'b0;
        wait_idle(60);
        check_val("bar_sync_once", n_sync - base_s, 1);
        check_val("bar_sync_after_fall", last_sync > fall_cyc, 1);
        check_val("bar_exec_after_sync", last_iv > last_sync, 1);
        check_val("bar_issues", n_issue - base, 2);

        // Flush and wrap
        eu_busy = 1'b1;
        base = n_issue;
        for (int i = 0; i < 5; i++) push(32'h0000_0C00 + i, 1);
        for (int i = 0; i < DEPTH - 6; i++) push(32'h8000_0C00 + i, 1);
        k = 0;
        while (n_issue - base < 5 && k < 200) begin
            tick();
            k++;
        end
        tick();
        check_val("wrap_five_issued", n_issue - base, 5);
        check_val("wrap_count_before", q_count, DEPTH - 6);
        for (int i = 0; i < 5; i++) push(32'h8000_0D00 + i, 1);
        check_val("wrap_count_full", q_count, DEPTH - 1);
        flush = 1'b1;
        h2f_write = 1'b1;
        h2f_io = 32'h0000_1234;
        tick();
        flush = 1'b0;
        h2f_write = 1'b0;
        exp_q.delete();
        check_val("flush_count", q_count, 0);
        check_val("flush_empty", q_empty, 1);
        check_val("flush_ovf", q_overflow, 0);
        check_val("flush_idle", sched_busy, 0);
        eu_busy = 1'b0;
        base = n_issue;
        repeat (20) tick();
        check_val("flush_no_issue", n_issue - base, 0);
        check_val("flush_count_stays", q_count, 0);

        // Randomized traffic
        cu_rand = 1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) ldst_busy = ~ldst_busy;
            if ($urandom_range(0, 3) == 0) move_busy = ~move_busy;
            if ($urandom_range(0, 3) == 0) eu_busy = ~eu_busy;
            wr = (exp_q.size() < DEPTH - 3) && ($urandom_range(0, 2) == 0);
            w = $urandom;
            h2f_io = w;
            h2f_write = wr;
            tick();
            h2f_write = 1'b0;
            if (wr) exp_q.push_back(w);
        end
        ldst_busy = 1'b0;
        move_busy = 1'b0;
        eu_busy = 1'b0;
        wait_idle(800);
        check_val("rand_overflow", q_overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
